// File: rtl/sii_niu_inbound_rcv.sv
// SII-side receiver for NIU inbound DMA headers/payload with queue occupancy and credit return.
// Define SII_NIU_PARITY_CHK_EN to build the per-lane even-parity checker; otherwise rcv_perr is tied 0.
module sii_niu_inbound_rcv #(
  parameter int OQ_DEPTH = 16,
  parameter int BQ_DEPTH = 4
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         niu_sii_hdr_vld,
  input  logic         niu_sii_reqbypass,
  input  logic         niu_sii_datareq,
  input  logic         niu_sii_datareq16,
  input  logic [127:0] niu_sii_data,
  input  logic [7:0]   niu_sii_parity,
  input  logic [15:0]  niu_sii_be,
  input  logic         oq_deq,
  input  logic         bq_deq,
  output logic         sii_niu_oqdq,
  output logic         sii_niu_bqdq,
  output logic         rcv_vld,
  output logic         rcv_byp,
  output logic         rcv_sop,
  output logic         rcv_eop,
  output logic [127:0] rcv_data,
  output logic [15:0]  rcv_be,
  output logic         rcv_perr,
  output logic         err_proto,
  output logic         err_ovf
);

  localparam int OQW = $clog2(OQ_DEPTH + 1);
  localparam int BQW = $clog2(BQ_DEPTH + 1);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t         state, state_nxt;
  logic [1:0]     beats_left, beats_left_nxt;
  logic           cur_byp, cur_byp_nxt;
  logic           cur_drop, cur_drop_nxt;
  logic [OQW-1:0] oq_cnt;
  logic [BQW-1:0] bq_cnt;

  logic        oq_full, bq_full, tgt_full;
  logic        oq_inc, bq_inc, oq_dec, bq_dec;
  logic        fwd_vld, fwd_byp, fwd_sop, fwd_eop;
  logic [15:0] fwd_be;
  logic        proto_nxt, ovf_nxt, perr_nxt;

  assign oq_full  = (oq_cnt == OQW'(OQ_DEPTH));
  assign bq_full  = (bq_cnt == BQW'(BQ_DEPTH));
  assign tgt_full = niu_sii_reqbypass ? bq_full : oq_full;
  assign oq_dec   = oq_deq && (oq_cnt != '0);
  assign bq_dec   = bq_deq && (bq_cnt != '0);

  // Header classification and beat sequencing; a dropped transaction still walks its beats.
  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    cur_byp_nxt    = cur_byp;
    cur_drop_nxt   = cur_drop;
    fwd_vld        = 1'b0;
    fwd_byp        = 1'b0;
    fwd_sop        = 1'b0;
    fwd_eop        = 1'b0;
    fwd_be         = '0;
    proto_nxt      = 1'b0;
    ovf_nxt        = 1'b0;
    oq_inc         = 1'b0;
    bq_inc         = 1'b0;
    case (state)
      IDLE: begin
        if (niu_sii_hdr_vld) begin
          ovf_nxt      = tgt_full;
          oq_inc       = !niu_sii_reqbypass && !tgt_full;
          bq_inc       = niu_sii_reqbypass && !tgt_full;
          fwd_vld      = !tgt_full;
          fwd_byp      = niu_sii_reqbypass;
          fwd_sop      = 1'b1;
          fwd_be       = niu_sii_be;
          cur_byp_nxt  = niu_sii_reqbypass;
          cur_drop_nxt = tgt_full;
          if (niu_sii_datareq16) begin
            state_nxt      = PAYLOAD;
            beats_left_nxt = 2'd0;
          end else if (niu_sii_datareq) begin
            state_nxt      = PAYLOAD;
            beats_left_nxt = 2'd3;
          end else begin
            fwd_eop = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        fwd_vld   = !cur_drop;
        fwd_byp   = cur_byp;
        fwd_eop   = (beats_left == 2'd0);
        proto_nxt = niu_sii_hdr_vld;
        if (beats_left == 2'd0) begin
          state_nxt = IDLE;
        end else begin
          beats_left_nxt = beats_left - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SII_NIU_PARITY_CHK_EN
  logic [7:0] lane_err;

  always_comb begin
    lane_err = '0;
    for (int i = 0; i < 8; i++) begin
      lane_err[i] = (^niu_sii_data[16*i +: 16]) ^ niu_sii_parity[i];
    end
    perr_nxt = fwd_vld && (|lane_err);
  end
`else
  logic parity_unused;

  assign parity_unused = ^niu_sii_parity;
  assign perr_nxt      = 1'b0;
`endif

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      beats_left <= 2'd0;
      cur_byp    <= 1'b0;
      cur_drop   <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      cur_byp    <= cur_byp_nxt;
      cur_drop   <= cur_drop_nxt;
    end
  end

  // Simultaneous enqueue and dequeue on the same queue leave the count unchanged.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      oq_cnt <= '0;
      bq_cnt <= '0;
    end else begin
      if (oq_inc && !oq_dec) begin
        oq_cnt <= oq_cnt + 1'b1;
      end else if (!oq_inc && oq_dec) begin
        oq_cnt <= oq_cnt - 1'b1;
      end
      if (bq_inc && !bq_dec) begin
        bq_cnt <= bq_cnt + 1'b1;
      end else if (!bq_inc && bq_dec) begin
        bq_cnt <= bq_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      sii_niu_oqdq <= 1'b0;
      sii_niu_bqdq <= 1'b0;
      rcv_vld      <= 1'b0;
      rcv_byp      <= 1'b0;
      rcv_sop      <= 1'b0;
      rcv_eop      <= 1'b0;
      rcv_data     <= '0;
      rcv_be       <= '0;
      rcv_perr     <= 1'b0;
      err_proto    <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      sii_niu_oqdq <= oq_dec;
      sii_niu_bqdq <= bq_dec;
      rcv_vld      <= fwd_vld;
      rcv_byp      <= fwd_vld && fwd_byp;
      rcv_sop      <= fwd_vld && fwd_sop;
      rcv_eop      <= fwd_vld && fwd_eop;
      rcv_data     <= fwd_vld ? niu_sii_data : '0;
      rcv_be       <= fwd_vld ? fwd_be : '0;
      rcv_perr     <= perr_nxt;
      err_proto    <= proto_nxt;
      err_ovf      <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sii_niu_inbound_rcv.sv
// Scoreboard bench for sii_niu_inbound_rcv: directed vectors push expected events, a negedge monitor pops and compares.
module tb_sii_niu_inbound_rcv;

  logic         iol2clk = 1'b0;
  logic         rst_l   = 1'b1;
  logic         niu_sii_hdr_vld = 1'b0;
  logic         niu_sii_reqbypass = 1'b0;
  logic         niu_sii_datareq = 1'b0;
  logic         niu_sii_datareq16 = 1'b0;
  logic [127:0] niu_sii_data = '0;
  logic [7:0]   niu_sii_parity = '0;
  logic [15:0]  niu_sii_be = '0;
  logic         oq_deq = 1'b0;
  logic         bq_deq = 1'b0;
  logic         sii_niu_oqdq, sii_niu_bqdq;
  logic         rcv_vld, rcv_byp, rcv_sop, rcv_eop;
  logic [127:0] rcv_data;
  logic [15:0]  rcv_be;
  logic         rcv_perr, err_proto, err_ovf;

`ifdef SII_NIU_PARITY_CHK_EN
  localparam logic PERR_ON = 1'b1;
`else
  localparam logic PERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic         vld;
    logic         byp;
    logic         sop;
    logic         eop;
    logic [127:0] data;
    logic [15:0]  be;
    logic         perr;
    logic         ep;
    logic         eo;
    logic         oqdq;
    logic         bqdq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sii_niu_inbound_rcv #(.OQ_DEPTH(16), .BQ_DEPTH(4)) dut (
    .iol2clk           (iol2clk),
    .rst_l             (rst_l),
    .niu_sii_hdr_vld   (niu_sii_hdr_vld),
    .niu_sii_reqbypass (niu_sii_reqbypass),
    .niu_sii_datareq   (niu_sii_datareq),
    .niu_sii_datareq16 (niu_sii_datareq16),
    .niu_sii_data      (niu_sii_data),
    .niu_sii_parity    (niu_sii_parity),
    .niu_sii_be        (niu_sii_be),
    .oq_deq            (oq_deq),
    .bq_deq            (bq_deq),
    .sii_niu_oqdq      (sii_niu_oqdq),
    .sii_niu_bqdq      (sii_niu_bqdq),
    .rcv_vld           (rcv_vld),
    .rcv_byp           (rcv_byp),
    .rcv_sop           (rcv_sop),
    .rcv_eop           (rcv_eop),
    .rcv_data          (rcv_data),
    .rcv_be            (rcv_be),
    .rcv_perr          (rcv_perr),
    .err_proto         (err_proto),
    .err_ovf           (err_ovf)
  );

  always #5 iol2clk = ~iol2clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Any visible event on the output side consumes one scoreboard entry.
  always @(negedge iol2clk) begin
    exp_t act;
    exp_t ex;
    act = {rcv_vld, rcv_byp, rcv_sop, rcv_eop, rcv_data, rcv_be,
           rcv_perr, err_proto, err_ovf, sii_niu_oqdq, sii_niu_bqdq};
    if (rst_l && act != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event act=%h exp=none", act);
      end else begin
        ex = sb.pop_front();
        if (act !== ex) begin
          errors++;
          $display("[TB] FAIL event act v%b b%b s%b e%b d=%h be=%h pe%b ep%b eo%b oq%b bq%b exp v%b b%b s%b e%b d=%h be=%h pe%b ep%b eo%b oq%b bq%b",
                   act.vld, act.byp, act.sop, act.eop, act.data, act.be, act.perr, act.ep, act.eo, act.oqdq, act.bqdq,
                   ex.vld, ex.byp, ex.sop, ex.eop, ex.data, ex.be, ex.perr, ex.ep, ex.eo, ex.oqdq, ex.bqdq);
        end
      end
    end
  end

  function automatic logic [7:0] par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic exp_t mk(input logic vld, byp, sop, eop, input logic [127:0] d,
                              input logic [15:0] b, input logic perr, ep, eo, oqdq, bqdq);
    exp_t e;
    e.vld = vld; e.byp = byp; e.sop = sop; e.eop = eop; e.data = d; e.be = b;
    e.perr = perr; e.ep = ep; e.eo = eo; e.oqdq = oqdq; e.bqdq = bqdq;
    return e;
  endfunction

  task automatic expHdr(input logic byp, eop, input logic [127:0] d, input logic [15:0] b);
    sb.push_back(mk(1'b1, byp, 1'b1, eop, d, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic expBeat(input logic byp, eop, input logic [127:0] d, input logic perr, ep);
    sb.push_back(mk(1'b1, byp, 1'b0, eop, d, 16'h0, perr, ep, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic expEvt(input logic eo, oqdq, bqdq);
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0, eo, oqdq, bqdq));
  endtask

  task automatic clearInputs();
    niu_sii_hdr_vld = 1'b0; niu_sii_reqbypass = 1'b0; niu_sii_datareq = 1'b0;
    niu_sii_datareq16 = 1'b0; niu_sii_data = '0; niu_sii_parity = '0; niu_sii_be = '0;
    oq_deq = 1'b0; bq_deq = 1'b0;
  endtask

  // One input cycle: drive, let the rising edge capture it, then return to idle inputs.
  task automatic applyStimulus(input logic hdr, byp, dreq, d16, input logic [127:0] d,
                               input logic [15:0] b, input logic [7:0] pflip, input logic oqd, bqd);
    niu_sii_hdr_vld = hdr; niu_sii_reqbypass = byp; niu_sii_datareq = dreq;
    niu_sii_datareq16 = d16; niu_sii_data = d; niu_sii_parity = par(d) ^ pflip;
    niu_sii_be = b; oq_deq = oqd; bq_deq = bqd;
    @(posedge iol2clk);
    #1;
    clearInputs();
  endtask

  task automatic sendHdr(input logic byp, dreq, d16, input logic [127:0] d, input logic [15:0] b);
    applyStimulus(1'b1, byp, dreq, d16, d, b, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic sendBeat(input logic [127:0] d, input logic [7:0] pflip, input logic hdr);
    applyStimulus(hdr, hdr, 1'b0, 1'b0, d, 16'hFFFF, pflip, 1'b0, 1'b0);
  endtask

  task automatic sendDeq(input logic oqd, bqd);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 16'h0, 8'h0, oqd, bqd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 16'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic checkCounts(input string name, input int oq, input int bq);
    checkOutput({name, "_oq_cnt"}, longint'(dut.oq_cnt), longint'(oq));
    checkOutput({name, "_bq_cnt"}, longint'(dut.bq_cnt), longint'(bq));
  endtask

  initial begin
    #1 rst_l = 1'b0;
    #2;
    checkOutput("reset_rcv_vld", longint'(rcv_vld), 0);
    checkOutput("reset_outputs", longint'({rcv_sop, rcv_eop, rcv_perr, err_proto, err_ovf, sii_niu_oqdq, sii_niu_bqdq}), 0);
    checkCounts("reset", 0, 0);
    #19 rst_l = 1'b1;
    @(posedge iol2clk);
    #1;

    $display("[TB] read header, ordered queue");
    expHdr(1'b0, 1'b1, 128'h1234, 16'hFFFF);
    sendHdr(1'b0, 1'b0, 1'b0, 128'h1234, 16'hFFFF);
    checkCounts("read", 1, 0);

    $display("[TB] 64B bypass write");
    expHdr(1'b1, 1'b0, 128'h100, 16'h00FF);
    expBeat(1'b1, 1'b0, 128'hA, 1'b0, 1'b0);
    expBeat(1'b1, 1'b0, 128'hB, 1'b0, 1'b0);
    expBeat(1'b1, 1'b0, 128'hC, 1'b0, 1'b0);
    expBeat(1'b1, 1'b1, 128'hD, 1'b0, 1'b0);
    sendHdr(1'b1, 1'b1, 1'b0, 128'h100, 16'h00FF);
    sendBeat(128'hA, 8'h0, 1'b0);
    sendBeat(128'hB, 8'h0, 1'b0);
    sendBeat(128'hC, 8'h0, 1'b0);
    sendBeat(128'hD, 8'h0, 1'b0);
    checkCounts("wr64", 1, 1);

    $display("[TB] 16B write then back-to-back read");
    expHdr(1'b0, 1'b0, 128'h200, 16'h000F);
    expBeat(1'b0, 1'b1, 128'h55, 1'b0, 1'b0);
    expHdr(1'b0, 1'b1, 128'h300, 16'hFFFF);
    sendHdr(1'b0, 1'b1, 1'b1, 128'h200, 16'h000F);
    sendBeat(128'h55, 8'h0, 1'b0);
    sendHdr(1'b0, 1'b0, 1'b0, 128'h300, 16'hFFFF);
    checkCounts("wr16", 3, 1);

    $display("[TB] header strobe during payload");
    expHdr(1'b0, 1'b0, 128'h400, 16'hF0F0);
    expBeat(1'b0, 1'b0, 128'h41, 1'b0, 1'b0);
    expBeat(1'b0, 1'b0, 128'h42, 1'b0, 1'b1);
    expBeat(1'b0, 1'b0, 128'h43, 1'b0, 1'b0);
    expBeat(1'b0, 1'b1, 128'h44, 1'b0, 1'b0);
    sendHdr(1'b0, 1'b1, 1'b0, 128'h400, 16'hF0F0);
    sendBeat(128'h41, 8'h0, 1'b0);
    sendBeat(128'h42, 8'h0, 1'b1);
    sendBeat(128'h43, 8'h0, 1'b0);
    sendBeat(128'h44, 8'h0, 1'b0);
    checkCounts("proto", 4, 1);

    $display("[TB] parity lane 3 flipped on payload beat 2");
    expHdr(1'b0, 1'b0, 128'h500, 16'hFFFF);
    expBeat(1'b0, 1'b0, 128'h51, 1'b0, 1'b0);
    expBeat(1'b0, 1'b0, 128'h0123_4567_89AB_CDEF_0000_0000_0000_0052, PERR_ON, 1'b0);
    expBeat(1'b0, 1'b0, 128'h53, 1'b0, 1'b0);
    expBeat(1'b0, 1'b1, 128'h54, 1'b0, 1'b0);
    sendHdr(1'b0, 1'b1, 1'b0, 128'h500, 16'hFFFF);
    sendBeat(128'h51, 8'h0, 1'b0);
    sendBeat(128'h0123_4567_89AB_CDEF_0000_0000_0000_0052, 8'h08, 1'b0);
    sendBeat(128'h53, 8'h0, 1'b0);
    sendBeat(128'h54, 8'h0, 1'b0);
    checkCounts("parity", 5, 1);

    $display("[TB] header with simultaneous ordered dequeue");
    sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 128'h600, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 128'h600, 16'h1111, 8'h0, 1'b1, 1'b0);
    checkCounts("simul", 5, 1);

    $display("[TB] bypass queue overflow");
    expEvt(1'b0, 1'b0, 1'b1);
    sendDeq(1'b0, 1'b1);
    checkCounts("bq_drain", 5, 0);
    for (int i = 0; i < 4; i++) begin
      expHdr(1'b1, 1'b1, 128'(32'h700 + i), 16'hFFFF);
      sendHdr(1'b1, 1'b0, 1'b0, 128'(32'h700 + i), 16'hFFFF);
    end
    expEvt(1'b1, 1'b0, 1'b0);
    sendHdr(1'b1, 1'b0, 1'b0, 128'h704, 16'hFFFF);
    checkCounts("bq_full", 5, 4);
    expEvt(1'b1, 1'b0, 1'b0);
    sendHdr(1'b1, 1'b1, 1'b0, 128'h780, 16'hFFFF);
    sendBeat(128'h81, 8'h0, 1'b0);
    sendBeat(128'h82, 8'h0, 1'b0);
    sendBeat(128'h83, 8'h0, 1'b0);
    sendBeat(128'h84, 8'h0, 1'b0);
    expHdr(1'b0, 1'b1, 128'h800, 16'hFFFF);
    sendHdr(1'b0, 1'b0, 1'b0, 128'h800, 16'hFFFF);
    checkCounts("drop_wr", 6, 4);
    expEvt(1'b0, 1'b0, 1'b1);
    sendDeq(1'b0, 1'b1);
    checkCounts("bq_deq", 6, 3);
    for (int i = 0; i < 3; i++) begin
      expEvt(1'b0, 1'b0, 1'b1);
      sendDeq(1'b0, 1'b1);
    end
    sendDeq(1'b0, 1'b1);
    idle(1);
    checkCounts("bq_empty", 6, 0);

    $display("[TB] ordered queue overflow and drain");
    for (int i = 0; i < 10; i++) begin
      expHdr(1'b0, 1'b1, 128'(32'h900 + i), 16'hFFFF);
      sendHdr(1'b0, 1'b0, 1'b0, 128'(32'h900 + i), 16'hFFFF);
    end
    checkCounts("oq_full", 16, 0);
    expEvt(1'b1, 1'b0, 1'b0);
    sendHdr(1'b0, 1'b0, 1'b0, 128'h9FF, 16'hFFFF);
    checkCounts("oq_ovf", 16, 0);
    for (int i = 0; i < 16; i++) begin
      expEvt(1'b0, 1'b1, 1'b0);
      sendDeq(1'b1, 1'b0);
    end
    sendDeq(1'b1, 1'b0);
    idle(1);
    checkCounts("oq_empty", 0, 0);

    $display("[TB] reset during 64B write");
    expHdr(1'b0, 1'b0, 128'hA00, 16'hFFFF);
    expBeat(1'b0, 1'b0, 128'hA1, 1'b0, 1'b0);
    sendHdr(1'b0, 1'b1, 1'b0, 128'hA00, 16'hFFFF);
    sendBeat(128'hA1, 8'h0, 1'b0);
    niu_sii_data = 128'hA2;
    niu_sii_parity = par(128'hA2);
    @(negedge iol2clk);
    #1 rst_l = 1'b0;
    #1;
    checkOutput("midrst_rcv_vld", longint'(rcv_vld), 0);
    checkOutput("midrst_rcv_data", longint'(rcv_data[63:0]), 0);
    checkCounts("midrst", 0, 0);
    clearInputs();
    repeat (2) @(posedge iol2clk);
    @(negedge iol2clk);
    #1 rst_l = 1'b1;
    @(posedge iol2clk);
    #1;
    expHdr(1'b0, 1'b1, 128'hB00, 16'hFFFF);
    sendHdr(1'b0, 1'b0, 1'b0, 128'hB00, 16'hFFFF);
    checkCounts("postrst", 1, 0);
    expEvt(1'b0, 1'b1, 1'b0);
    sendDeq(1'b1, 1'b0);

    idle(4);
    checkOutput("scoreboard_empty", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
